// File: rtl/uart_rx.sv
// uart_rx: oversampling receiver for 8 data bits + control bit (AND of data) + stop.
// Samples each bit at its midpoint and reports the byte with a one-cycle rx_done pulse
// along with frame and control error flags.
module uart_rx #(
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       rx_tick,
    output logic [7:0] data_out,
    output logic       rx_done,
    output logic       frame_error,
    output logic       control_error,
    output logic       busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t        state;
    state_t        state_next;
    logic          rx_meta;
    logic          rx_s;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    bit_cnt;
    logic [8:0]    shift;
    logic          mid_tick;
    logic          last_tick;

    assign mid_tick  = rx_tick && (tick_cnt == TICK_MID);
    assign last_tick = rx_tick && (tick_cnt == TICK_LAST);

    // Two-flop synchronizer for the asynchronous serial line (idles high)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; illegal encodings fall back to IDLE
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (rx_tick && !rx_s) state_next = START;
            START:     if (mid_tick) state_next = rx_s ? IDLE : DATA;
            DATA:      if (last_tick && (bit_cnt == 4'd8)) state_next = STOP;
            STOP:      if (last_tick) state_next = rx_s ? IDLE : WAIT_IDLE;
            WAIT_IDLE: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Tick/bit counters, shift register and registered frame outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            data_out      <= '0;
            rx_done       <= 1'b0;
            frame_error   <= 1'b0;
            control_error <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_tick && !rx_s) tick_cnt <= '0;
                end
                START: begin
                    if (mid_tick) begin
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                    end else if (rx_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (last_tick) begin
                        shift    <= {rx_s, shift[8:1]};
                        tick_cnt <= '0;
                        bit_cnt  <= bit_cnt + 1'b1;
                    end else if (rx_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (last_tick) begin
                        data_out      <= shift[7:0];
                        control_error <= shift[8] ^ (&shift[7:0]);
                        frame_error   <= ~rx_s;
                        rx_done       <= 1'b1;
                        tick_cnt      <= '0;
                    end else if (rx_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Busy whenever a frame is in progress or a break is being waited out
    always_comb begin
        busy = (state != IDLE);
    end

endmodule
